// File: rtl/fifo_pkg.sv
// ============================================================================
// Module  : fifo_pkg
// Brief   : Pointer-width constants and Gray/binary conversion helpers shared
//           by the read-port and write-port halves of the async FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_ADDRSIZE = 8;
    localparam int c_PTR_W    = c_ADDRSIZE + 1;

    // Conversion helpers work on a fixed wide vector; callers zero-extend
    // their pointer in and cast the result back to the pointer width.
    localparam int c_FN_W = 32;

    typedef logic [c_PTR_W-1:0] ptr_t;

    function automatic logic [c_FN_W-1:0] bin2gray(input logic [c_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Upper bits are zero for any narrower pointer, so a full-width prefix
    // XOR yields the right answer regardless of the caller's width.
    function automatic logic [c_FN_W-1:0] gray2bin(input logic [c_FN_W-1:0] gray);
        logic [c_FN_W-1:0] bin;
        bin[c_FN_W-1] = gray[c_FN_W-1];
        for (int i = c_FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_read_port_sync.sv
// ============================================================================
// Module  : sync_w2r
// Brief   : Multi-flop synchroniser for a Gray-coded pointer crossing into the
//           local clock domain; also instantiated mirrored as the r2w sync.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_w2r #(
    parameter int WIDTH       = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stage_d [SYNC_STAGES];
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Pure flop chain: any logic between stages would defeat the Gray
    // single-bit-change guarantee.
    always_comb begin
        stage_d[0] = i_d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign o_q = stage_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fifo_read_port.sv
// ============================================================================
// Module  : fifo_read_port
// Brief   : Read-domain controller of the async FIFO: write-pointer sync,
//           read pointer, empty flag, fill level and a FWFT valid/ready stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_port
    import fifo_pkg::*;
#(
    parameter int WORDSIZE    = 8,
    parameter int ADDRSIZE    = c_ADDRSIZE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr_gray,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [WORDSIZE-1:0] rdata,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [WORDSIZE-1:0] rd_data,
    output logic                empty,
    output logic [ADDRSIZE:0]   rd_count
);

    localparam int c_PW = ADDRSIZE + 1;

    logic [ADDRSIZE:0]   wq_sync;
    logic                load;

    logic [ADDRSIZE:0]   rbin_d,      rbin_q;
    logic [ADDRSIZE:0]   rptr_gray_d, rptr_gray_q;
    logic                empty_d,     empty_q;
    logic                rd_valid_d,  rd_valid_q;
    logic [WORDSIZE-1:0] rd_data_d,   rd_data_q;
    logic [ADDRSIZE:0]   rd_count_d,  rd_count_q;

    sync_w2r #(
        .WIDTH       (c_PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk (rclk),
        .rst (rrst),
        .i_d (wptr_gray),
        .o_q (wq_sync)
    );

    always_comb begin
        // The output register refills whenever it is free or being drained,
        // giving one word per clock under sustained reading.
        load        = ~empty_q & (~rd_valid_q | rd_ready);
        rbin_d      = rbin_q + c_PW'(load);
        rptr_gray_d = c_PW'(bin2gray(c_FN_W'(rbin_d)));

        // Compare against the post-load pointer so the flag rises on the
        // same edge that takes the last word out of memory.
        empty_d     = (rptr_gray_d == wq_sync);

        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        if (load) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rdata;
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
        end

        // Synchronised write pointer lags reality, so this never overstates.
        rd_count_d  = c_PW'(gray2bin(c_FN_W'(wq_sync))) - rbin_q;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            empty_q     <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_count_q  <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_gray_q <= rptr_gray_d;
            empty_q     <= empty_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_count_q  <= rd_count_d;
        end
    end

    assign rptr_gray = rptr_gray_q;
    assign raddr     = rbin_q[ADDRSIZE-1:0];
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign empty     = empty_q;
    assign rd_count  = rd_count_q;

endmodule

`default_nettype wire
